sdram_arbiter: RTL and testbench

- Shares the single Gowin SDRAM controller user interface (cmd_en/cmd/addr/dqm/data/data_len, cmd_ack, init_done) between two requesters, typically the ramio cache port (m0) and a DMA/flash-loader port (m1).
- Also owns the periodic auto-refresh schedule: it issues the controller's REFRESH command itself, so requesters never do.
- Sits between requesters and SDRAM_Controller_HS_Top, clocked on the controller's user clock.

---
 rtl/sdram_arbiter_pkg.sv | 35 +++
 rtl/sdram_refresh_timer.sv | 76 +++++++
 rtl/sdram_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arbiter_pkg.sv
// Shared types and constants for the two-port SDRAM controller arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package sdram_arbiter_pkg;

    // Controller user-interface command encodings
    localparam logic [2:0] CMD_LOAD_MODE = 3'b000;
    localparam logic [2:0] CMD_REFRESH   = 3'b001;
    localparam logic [2:0] CMD_PRECHARGE = 3'b010;
    localparam logic [2:0] CMD_ACTIVATE  = 3'b011;
    localparam logic [2:0] CMD_WRITE     = 3'b100;
    localparam logic [2:0] CMD_READ      = 3'b101;

    // Address width carried inside the command bundle
    localparam int SDRC_ADDR_W = 21;

    typedef enum logic [2:0] {
        ST_WAIT_INIT = 3'd0,
        ST_IDLE      = 3'd1,
        ST_GRANT0    = 3'd2,
        ST_GRANT1    = 3'd3,
        ST_REF_ISSUE = 3'd4,
        ST_REF_BUSY  = 3'd5
    } state_t;

    // One command as presented to the controller (cmd_en travels separately)
    typedef struct packed {
        logic [2:0]             cmd;
        logic [SDRC_ADDR_W-1:0] addr;
        logic [3:0]             dqm;
        logic [31:0]            data;
        logic [7:0]             data_len;
    } sdrc_cmd_t;

endpackage

// File: rtl/sdram_refresh_timer.sv
// Auto-refresh interval counter with pending and sticky late flags.
// Latency: pending rises the cycle after the counter expires.
// Backpressure: pending holds until issue_done; a second expiry meanwhile sets late.
module sdram_refresh_timer
    import sdram_arbiter_pkg::*;
#(
    parameter int IntervalCycles = 405
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic abort,
    input  logic issue_done,
    output logic refresh_pending,
    output logic refresh_late
);

    localparam int CntW = (IntervalCycles > 1) ? $clog2(IntervalCycles) : 1;
    localparam logic [CntW-1:0] Reload = CntW'(IntervalCycles - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pending_q, pending_d;
    logic            late_q, late_d;
    logic            expire;

    // Count down while the controller is initialised; reload on expiry
    always_comb begin
        cnt_d  = cnt_q;
        expire = 1'b0;
        if (run) begin
            if (cnt_q == '0) begin
                cnt_d  = Reload;
                expire = 1'b1;
            end else begin
                cnt_d = cnt_q - CntW'(1);
            end
        end
    end

    // Pending is consumed by the issued refresh; an expiry that finds an
    // unconsumed refresh means the schedule slipped, which latches late
    always_comb begin
        pending_d = pending_q;
        late_d    = late_q;
        if (abort) begin
            pending_d = 1'b0;
        end else begin
            if (issue_done) begin
                pending_d = 1'b0;
            end
            if (expire) begin
                if (pending_q && !issue_done) begin
                    late_d = 1'b1;
                end
                pending_d = 1'b1;
            end
        end
    end

    // Timer state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= Reload;
            pending_q <= 1'b0;
            late_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            late_q    <= late_d;
        end
    end

    assign refresh_pending = pending_q;
    assign refresh_late    = late_q;

endmodule

// File: rtl/sdram_arbiter.sv
// Two-requester arbiter for the SDRAM controller user port; also schedules auto-refresh.
// Latency: grant registered one cycle after req is sampled; command path is combinational.
// Backpressure: holder keeps the port until it drops req; SDRAM_ARB_FIXED_PRIORITY_EN selects fixed m0 priority.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int RefreshIntervalCycles = 405,
    parameter int RefreshBusyCycles     = 8,
    parameter int AddressBitWidth       = 21
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       init_done,
    // requester 0
    input  logic                       m0_req,
    output logic                       m0_gnt,
    input  logic                       m0_cmd_en,
    input  logic [2:0]                 m0_cmd,
    input  logic [AddressBitWidth-1:0] m0_addr,
    input  logic [3:0]                 m0_dqm,
    input  logic [31:0]                m0_data,
    input  logic [7:0]                 m0_data_len,
    output logic                       m0_cmd_ack,
    // requester 1
    input  logic                       m1_req,
    output logic                       m1_gnt,
    input  logic                       m1_cmd_en,
    input  logic [2:0]                 m1_cmd,
    input  logic [AddressBitWidth-1:0] m1_addr,
    input  logic [3:0]                 m1_dqm,
    input  logic [31:0]                m1_data,
    input  logic [7:0]                 m1_data_len,
    output logic                       m1_cmd_ack,
    // controller side
    output logic                       sdrc_cmd_en,
    output logic [2:0]                 sdrc_cmd,
    output logic [AddressBitWidth-1:0] sdrc_addr,
    output logic [3:0]                 sdrc_dqm,
    output logic [31:0]                sdrc_data,
    output logic [7:0]                 sdrc_data_len,
    input  logic                       sdrc_cmd_ack,
    output logic                       refresh_late
);

    localparam int BusyW = (RefreshBusyCycles > 1) ? $clog2(RefreshBusyCycles) : 1;
    localparam logic [BusyW-1:0] BusyReload = BusyW'(RefreshBusyCycles - 1);

    state_t           state_q, state_d;
    logic             m0_gnt_q, m0_gnt_d;
    logic             m1_gnt_q, m1_gnt_d;
    logic [BusyW-1:0] busy_q, busy_d;
    logic             refresh_pending;
    logic             issue_done;
    logic             timer_run;
    sdrc_cmd_t        m0_bundle, m1_bundle, out_bundle;
    logic             out_cmd_en;
`ifndef SDRAM_ARB_FIXED_PRIORITY_EN
    logic             rr_last_q, rr_last_d;
`endif

    // Refresh interval only runs once the controller is up and we have left WAIT_INIT
    assign timer_run = init_done && (state_q != ST_WAIT_INIT);

    sdram_refresh_timer #(
        .IntervalCycles (RefreshIntervalCycles)
    ) u_refresh_timer (
        .clk             (clk),
        .rst             (rst),
        .run             (timer_run),
        .abort           (!init_done),
        .issue_done      (issue_done),
        .refresh_pending (refresh_pending),
        .refresh_late    (refresh_late)
    );

    // Pack requester command fields into bundles for the output mux
    always_comb begin
        m0_bundle = '{cmd: m0_cmd, addr: SDRC_ADDR_W'(m0_addr), dqm: m0_dqm,
                      data: m0_data, data_len: m0_data_len};
        m1_bundle = '{cmd: m1_cmd, addr: SDRC_ADDR_W'(m1_addr), dqm: m1_dqm,
                      data: m1_data, data_len: m1_data_len};
    end

    // Next-state: init gate, refresh ahead of requesters, holder keeps the port until it lets go
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        issue_done = 1'b0;
`ifndef SDRAM_ARB_FIXED_PRIORITY_EN
        rr_last_d  = rr_last_q;
`endif
        if (!init_done) begin
            state_d = ST_WAIT_INIT;
        end else begin
            case (state_q)
                ST_WAIT_INIT: state_d = ST_IDLE;
                ST_IDLE: begin
                    if (refresh_pending) begin
                        state_d = ST_REF_ISSUE;
                    end else if (m0_req && m1_req) begin
`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
                        state_d = ST_GRANT0;
`else
                        state_d = rr_last_q ? ST_GRANT0 : ST_GRANT1;
`endif
                    end else if (m0_req) begin
                        state_d = ST_GRANT0;
                    end else if (m1_req) begin
                        state_d = ST_GRANT1;
                    end
                end
                ST_GRANT0: begin
                    if (!m0_req) begin
                        state_d = ST_IDLE;
`ifndef SDRAM_ARB_FIXED_PRIORITY_EN
                        rr_last_d = 1'b0;
`endif
                    end
                end
                ST_GRANT1: begin
                    if (!m1_req) begin
                        state_d = ST_IDLE;
`ifndef SDRAM_ARB_FIXED_PRIORITY_EN
                        rr_last_d = 1'b1;
`endif
                    end
                end
                ST_REF_ISSUE: begin
                    if (sdrc_cmd_ack) begin
                        issue_done = 1'b1;
                        busy_d     = BusyReload;
                        state_d    = ST_REF_BUSY;
                    end
                end
                ST_REF_BUSY: begin
                    if (busy_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        busy_d = busy_q - BusyW'(1);
                    end
                end
                default: state_d = ST_WAIT_INIT;
            endcase
        end
    end

    // Grants are flops decoded from the next state so they never glitch
    always_comb begin
        m0_gnt_d = (state_d == ST_GRANT0);
        m1_gnt_d = (state_d == ST_GRANT1);
    end

    // Controller mux: only the holder reaches the controller and sees cmd_ack
    always_comb begin
        out_cmd_en = 1'b0;
        out_bundle = '0;
        m0_cmd_ack = 1'b0;
        m1_cmd_ack = 1'b0;
        case (state_q)
            ST_GRANT0: begin
                out_cmd_en = m0_cmd_en;
                out_bundle = m0_bundle;
                m0_cmd_ack = sdrc_cmd_ack;
            end
            ST_GRANT1: begin
                out_cmd_en = m1_cmd_en;
                out_bundle = m1_bundle;
                m1_cmd_ack = sdrc_cmd_ack;
            end
            ST_REF_ISSUE: begin
                out_cmd_en     = 1'b1;
                out_bundle.cmd = CMD_REFRESH;
            end
            default: ;
        endcase
    end

    assign sdrc_cmd_en   = out_cmd_en;
    assign sdrc_cmd      = out_bundle.cmd;
    assign sdrc_addr     = AddressBitWidth'(out_bundle.addr);
    assign sdrc_dqm      = out_bundle.dqm;
    assign sdrc_data     = out_bundle.data;
    assign sdrc_data_len = out_bundle.data_len;
    assign m0_gnt        = m0_gnt_q;
    assign m1_gnt        = m1_gnt_q;

    // Arbiter state; reset parks in WAIT_INIT so nothing is granted before the controller is ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_WAIT_INIT;
            m0_gnt_q  <= 1'b0;
            m1_gnt_q  <= 1'b0;
            busy_q    <= '0;
`ifndef SDRAM_ARB_FIXED_PRIORITY_EN
            rr_last_q <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            m0_gnt_q  <= m0_gnt_d;
            m1_gnt_q  <= m1_gnt_d;
            busy_q    <= busy_d;
`ifndef SDRAM_ARB_FIXED_PRIORITY_EN
            rr_last_q <= rr_last_d;
`endif
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a 16-cycle refresh interval.
// Edge numbers in comments count posedges after the step that sets them up.
module tb_sdram_arbiter;
    import sdram_arbiter_pkg::*;

    localparam int AW = 21;

    logic          clk = 1'b0;
    logic          rst;
    logic          init_done;
    logic          m0_req, m0_gnt, m0_cmd_en, m0_cmd_ack;
    logic [2:0]    m0_cmd;
    logic [AW-1:0] m0_addr;
    logic [3:0]    m0_dqm;
    logic [31:0]   m0_data;
    logic [7:0]    m0_data_len;
    logic          m1_req, m1_gnt, m1_cmd_en, m1_cmd_ack;
    logic [2:0]    m1_cmd;
    logic [AW-1:0] m1_addr;
    logic [3:0]    m1_dqm;
    logic [31:0]   m1_data;
    logic [7:0]    m1_data_len;
    logic          sdrc_cmd_en, sdrc_cmd_ack, refresh_late;
    logic [2:0]    sdrc_cmd;
    logic [AW-1:0] sdrc_addr;
    logic [3:0]    sdrc_dqm;
    logic [31:0]   sdrc_data;
    logic [7:0]    sdrc_data_len;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    // Controller model: accepts every command in the cycle it is presented
    assign sdrc_cmd_ack = sdrc_cmd_en;

    sdram_arbiter #(
        .RefreshIntervalCycles (16),
        .RefreshBusyCycles     (8),
        .AddressBitWidth       (AW)
    ) dut (
        .clk (clk), .rst (rst), .init_done (init_done),
        .m0_req (m0_req), .m0_gnt (m0_gnt), .m0_cmd_en (m0_cmd_en), .m0_cmd (m0_cmd),
        .m0_addr (m0_addr), .m0_dqm (m0_dqm), .m0_data (m0_data), .m0_data_len (m0_data_len),
        .m0_cmd_ack (m0_cmd_ack),
        .m1_req (m1_req), .m1_gnt (m1_gnt), .m1_cmd_en (m1_cmd_en), .m1_cmd (m1_cmd),
        .m1_addr (m1_addr), .m1_dqm (m1_dqm), .m1_data (m1_data), .m1_data_len (m1_data_len),
        .m1_cmd_ack (m1_cmd_ack),
        .sdrc_cmd_en (sdrc_cmd_en), .sdrc_cmd (sdrc_cmd), .sdrc_addr (sdrc_addr),
        .sdrc_dqm (sdrc_dqm), .sdrc_data (sdrc_data), .sdrc_data_len (sdrc_data_len),
        .sdrc_cmd_ack (sdrc_cmd_ack), .refresh_late (refresh_late)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_req = 0; m0_cmd_en = 0; m0_cmd = 0; m0_addr = 0; m0_dqm = 0; m0_data = 0; m0_data_len = 0;
        m1_req = 0; m1_cmd_en = 0; m1_cmd = 0; m1_addr = 0; m1_dqm = 0; m1_data = 0; m1_data_len = 0;
    endtask

    // Hold reset two cycles then release; next posedge is edge 1
    task automatic do_reset(input logic init);
        rst = 1'b1;
        clear_inputs();
        init_done = init;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int  ref_pos[$];
    logic bad;

    initial begin
        // ---- reset values with busy-looking inputs ----
        rst = 1'b1; init_done = 1'b1;
        clear_inputs();
        m0_req = 1; m0_cmd_en = 1; m0_data = 32'hFFFF_FFFF; m1_req = 1; m1_cmd_en = 1;
        tick(); tick();
        chk("rst_outs", {m0_gnt, m1_gnt, m0_cmd_ack, m1_cmd_ack, sdrc_cmd_en, refresh_late}, 6'b0);
        chk("rst_data", sdrc_data, 32'h0);

        // ---- segment A: init gating, mirror, refresh_late ----
        do_reset(1'b0);
        m0_req = 1; m0_cmd_en = 1; m0_cmd = CMD_READ;
        bad = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            bad = bad | m0_gnt | m1_gnt | sdrc_cmd_en;
        end
        chk("pre_init_quiet", bad, 1'b0);
        m0_cmd_en = 0;
        init_done = 1'b1;
        tick();                                   // E1: WAIT_INIT -> IDLE
        chk("init_e1_gnt", m0_gnt, 1'b0);
        tick();                                   // E2: GRANT0
        chk("init_e2_gnt", m0_gnt, 1'b1);
        m0_cmd_en = 1; m0_cmd = CMD_WRITE; m0_addr = 21'h1234; m0_data = 32'hDEAD_BEEF;
        m0_dqm = 4'h3; m0_data_len = 8'd5;
        m1_cmd_en = 1; m1_cmd = CMD_READ; m1_addr = 21'h1F_FFFF; m1_data = 32'h0BAD_F00D;
        #1;
        chk("mir_en",   sdrc_cmd_en, 1'b1);
        chk("mir_cmd",  sdrc_cmd, CMD_WRITE);
        chk("mir_addr", sdrc_addr, 21'h1234);
        chk("mir_data", sdrc_data, 32'hDEAD_BEEF);
        chk("mir_dqm_len", {sdrc_dqm, sdrc_data_len}, {4'h3, 8'd5});
        chk("mir_acks", {m0_cmd_ack, m1_cmd_ack}, 2'b10);
        m0_cmd_en = 0;
        // expiries at E17 (pending) and E33 (late); holder is never preempted
        for (int k = 3; k <= 42; k++) begin
            tick();
            if (k == 20) begin
                chk("late_e20", refresh_late, 1'b0);
                chk("hold_e20", m0_gnt, 1'b1);
            end
        end
        chk("late_e42", refresh_late, 1'b1);
        chk("hold_e42", m0_gnt, 1'b1);
        m0_req = 0;
        tick();                                   // E43: IDLE
        chk("rel_gnt", m0_gnt, 1'b0);
        chk("idle_quiet", sdrc_cmd_en, 1'b0);
        tick();                                   // E44: REF_ISSUE
        chk("ref_cmd", {sdrc_cmd_en, sdrc_cmd}, {1'b1, CMD_REFRESH});
        chk("ref_addr", sdrc_addr, 21'h0);
        chk("ref_acks", {m0_cmd_ack, m1_cmd_ack}, 2'b00);

        // ---- segment B: periodic refresh, grant after busy window ----
        do_reset(1'b1);
        bad = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (sdrc_cmd_en && sdrc_cmd == CMD_REFRESH) ref_pos.push_back(k);
            if (k >= 51 && k <= 59 && m0_gnt) bad = 1'b1;
            if (k == 52) m0_req = 1;              // request lands mid REF_BUSY
        end
        chk("ref_count", ref_pos.size(), 3);
        if (ref_pos.size() == 3) begin
            chk("ref_pos0", ref_pos[0], 18);
            chk("ref_pos1", ref_pos[1], 34);
            chk("ref_pos2", ref_pos[2], 50);
        end
        chk("busy_no_gnt", bad, 1'b0);
        chk("busy_then_gnt", m0_gnt, 1'b1);

        // ---- segment C: arbitration, abort on init_done loss, async reset ----
        do_reset(1'b1);
        tick();                                   // E1: IDLE
        m0_req = 1; m1_req = 1;
        tick();                                   // E2: m0 wins first tie
        chk("arb_e2", {m0_gnt, m1_gnt}, 2'b10);
        m0_req = 0;
        tick();                                   // E3: back to IDLE
        chk("arb_e3", {m0_gnt, m1_gnt}, 2'b00);
        m0_req = 1;
        tick();                                   // E4: both request again
`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
        chk("arb_e4", {m0_gnt, m1_gnt}, 2'b10);
`else
        chk("arb_e4", {m0_gnt, m1_gnt}, 2'b01);
        m1_cmd_en = 1; m1_addr = 21'h0ABCD; m1_data = 32'h1234_5678;
        #1;
        chk("m1_addr", sdrc_addr, 21'h0ABCD);
        chk("m1_acks", {m0_cmd_ack, m1_cmd_ack}, 2'b01);
`endif
        m1_req = 0;
        tick();                                   // E5
        m1_req = 1;
        tick();                                   // E6: m0 again in both builds
        chk("arb_e6", {m0_gnt, m1_gnt}, 2'b10);
        m0_req = 0; m1_req = 0;
        tick();                                   // E7: IDLE
        m1_req = 1; m1_cmd_en = 1;
        tick();                                   // E8: lone m1
        chk("arb_e8", {m0_gnt, m1_gnt}, 2'b01);
        init_done = 0;
        tick();                                   // E9: aborted to WAIT_INIT
        chk("abort_gnt", m1_gnt, 1'b0);
        init_done = 1;
        tick();                                   // E10: IDLE
        tick();                                   // E11: GRANT1
        chk("regrant", m1_gnt, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst", {m1_gnt, sdrc_cmd_en}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
